// File: rtl/fifo_rptr_empty_ctrl_if.sv
// Read-side bus of the async FIFO read-pointer controller.
// The master (consumer and synchronizer side) drives the requests and the
// synchronized write pointer. The slave (the controller) drives the pointer,
// the flags and the fill level.
interface fifo_rptr_empty_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rae_th;
  logic                rclr_err;
  logic [ADDRSIZE-1:0] raddr;
  logic                rd_en;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;
  logic                rundf_sticky;

  modport master (
    output rinc, rq2_wptr, rae_th, rclr_err,
    input  raddr, rd_en, rptr, rempty, ralmost_empty, rlevel, runderflow, rundf_sticky
  );

  modport slave (
    input  rinc, rq2_wptr, rae_th, rclr_err,
    output raddr, rd_en, rptr, rempty, ralmost_empty, rlevel, runderflow, rundf_sticky
  );
endinterface

// File: rtl/fifo_rptr_empty_ctrl.sv
// Read-domain controller of the async FIFO.
// Owns the binary and Gray read pointers, the read address and enable, the
// empty and almost-empty flags, the fill level, and underflow reporting.
module fifo_rptr_empty_ctrl #(
  parameter int ADDRSIZE = 4
) (
  input logic                   rclk,
  input logic                   rrst_n,
  fifo_rptr_empty_ctrl_if.slave bus
);
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rgray;
  logic              rempty_q;
  logic              ralmost_empty_q;
  logic [ADDRSIZE:0] rlevel_q;
  logic              runderflow_q;
  logic              rundf_sticky_q;

  logic              acc;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] level_next;

  // Accepted read: advance the binary pointer and derive its Gray form.
  always_comb begin
    acc       = bus.rinc & ~rempty_q;
    rbinnext  = rbin + {{ADDRSIZE{1'b0}}, acc};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  // Convert the synchronized Gray write pointer to binary and compute the level.
  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(bus.rq2_wptr >> i);
    end
    level_next = wbin_s - rbinnext;
  end

  // Pointer registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin  <= '0;
      rgray <= '0;
    end else begin
      rbin  <= rbinnext;
      rgray <= rgraynext;
    end
  end

  // Empty, level and almost-empty flags, evaluated against the post-read pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
    end else begin
      rempty_q        <= (rgraynext == bus.rq2_wptr);
      ralmost_empty_q <= (level_next <= bus.rae_th);
      rlevel_q        <= level_next;
    end
  end

  // Underflow pulse and sticky flag. A set in the same cycle beats a clear.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow_q   <= 1'b0;
      rundf_sticky_q <= 1'b0;
    end else begin
      runderflow_q <= bus.rinc & rempty_q;
      if (bus.rinc & rempty_q) begin
        rundf_sticky_q <= 1'b1;
      end else if (bus.rclr_err) begin
        rundf_sticky_q <= 1'b0;
      end
    end
  end

  // Output wiring. The enable and address are combinational so a read needs no extra cycle.
  always_comb begin
    bus.raddr         = rbin[ADDRSIZE-1:0];
    bus.rd_en         = acc;
    bus.rptr          = rgray;
    bus.rempty        = rempty_q;
    bus.ralmost_empty = ralmost_empty_q;
    bus.rlevel        = rlevel_q;
    bus.runderflow    = runderflow_q;
    bus.rundf_sticky  = rundf_sticky_q;
  end
endmodule

// File: tb/tb_fifo_rptr_empty_ctrl.sv
// Testbench for fifo_rptr_empty_ctrl. It uses randomized and directed stimulus
// and checks the outputs against an occupancy model built from entry counts.
module tb_fifo_rptr_empty_ctrl;
  localparam int AW  = 4;
  localparam int MOD = 1 << (AW + 1);

  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model state: total reads and writes (mod 2*depth) and the registered flags.
  int m_rd, m_wr, m_level, m_th;
  bit m_empty, m_ae, m_und, m_sticky;

  fifo_rptr_empty_ctrl_if #(.ADDRSIZE(AW)) bus ();

  fifo_rptr_empty_ctrl #(.ADDRSIZE(AW)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  always #5 rclk = ~rclk;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_level = 0;
    m_empty = 1; m_ae = 1; m_und = 0; m_sticky = 0;
  endtask

  // Drive one cycle, check the combinational outputs, clock, update the model, check the registered outputs.
  task automatic cycle(input bit inc, input int wr, input int th, input bit clr);
    bit acc;
    @(negedge rclk);
    bus.rinc = inc; bus.rq2_wptr = gray(wr); bus.rae_th = th[AW:0]; bus.rclr_err = clr;
    #1;
    acc = inc && !m_empty;
    checks++;
    if (bus.rd_en !== acc) begin
      errors++; $display("FAIL rd_en: got %b want %b", bus.rd_en, acc);
    end
    checks++;
    if (bus.raddr !== m_rd[AW-1:0]) begin
      errors++; $display("FAIL raddr: got %0d want %0d", bus.raddr, m_rd % (1 << AW));
    end
    @(posedge rclk);
    m_und    = inc && m_empty;
    m_sticky = m_und ? 1'b1 : (clr ? 1'b0 : m_sticky);
    m_rd     = (m_rd + int'(acc)) % MOD;
    m_wr     = wr % MOD;
    m_level  = (m_wr - m_rd + MOD) % MOD;
    m_empty  = (m_level == 0);
    m_ae     = (m_level <= th);
    #1;
    checks++;
    if (bus.rempty !== m_empty) begin
      errors++; $display("FAIL rempty: got %b want %b", bus.rempty, m_empty);
    end
    checks++;
    if (int'(bus.rlevel) != m_level) begin
      errors++; $display("FAIL rlevel: got %0d want %0d", bus.rlevel, m_level);
    end
    checks++;
    if (bus.ralmost_empty !== m_ae) begin
      errors++; $display("FAIL ralmost_empty: got %b want %b", bus.ralmost_empty, m_ae);
    end
    checks++;
    if (bus.runderflow !== m_und) begin
      errors++; $display("FAIL runderflow: got %b want %b", bus.runderflow, m_und);
    end
    checks++;
    if (bus.rundf_sticky !== m_sticky) begin
      errors++; $display("FAIL rundf_sticky: got %b want %b", bus.rundf_sticky, m_sticky);
    end
    checks++;
    if (bus.rptr !== gray(m_rd)) begin
      errors++; $display("FAIL rptr: got %b want %b", bus.rptr, gray(m_rd));
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({bus.rempty, bus.ralmost_empty, bus.rd_en, bus.runderflow, bus.rundf_sticky} !== 5'b11000) begin
      errors++;
      $display("FAIL %s flags: got e=%b ae=%b rd_en=%b und=%b st=%b want 1 1 0 0 0", tag,
               bus.rempty, bus.ralmost_empty, bus.rd_en, bus.runderflow, bus.rundf_sticky);
    end
    checks++;
    if (bus.rlevel !== '0 || bus.rptr !== '0 || bus.raddr !== '0) begin
      errors++;
      $display("FAIL %s regs: got level=%0d rptr=%b raddr=%0d want 0 0 0", tag, bus.rlevel, bus.rptr, bus.raddr);
    end
  endtask

  // Enter reset with rinc high, then leave reset cleanly.
  task automatic test_reset();
    rrst_n = 1'b0;
    bus.rinc = 1'b1; bus.rq2_wptr = '0; bus.rae_th = 5'd2; bus.rclr_err = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check_reset_values("reset_hold");
    @(negedge rclk);
    bus.rinc = 1'b0;
    rrst_n = 1'b1;
    model_reset();
  endtask

  // Write pointer becomes visible, then three reads drain the FIFO.
  task automatic test_fill_drain();
    cycle(0, 3, 2, 0);
    checks++;
    if (bus.rlevel !== 5'd3 || bus.rempty !== 1'b0 || bus.ralmost_empty !== 1'b0) begin
      errors++; $display("FAIL fill: got level=%0d e=%b ae=%b want 3 0 0", bus.rlevel, bus.rempty, bus.ralmost_empty);
    end
    for (int k = 0; k < 3; k++) cycle(1, 3, 2, 0);
    checks++;
    if (bus.rempty !== 1'b1 || bus.rptr !== 5'b00010 || bus.rlevel !== '0) begin
      errors++; $display("FAIL drain: got e=%b rptr=%b level=%0d want 1 00010 0", bus.rempty, bus.rptr, bus.rlevel);
    end
  endtask

  // Underflow pulse, sticky set-wins, then clear.
  task automatic test_underflow();
    cycle(1, m_wr, 2, 0);
    checks++;
    if (bus.runderflow !== 1'b1 || bus.rundf_sticky !== 1'b1 || bus.rptr !== 5'b00010) begin
      errors++; $display("FAIL underflow: got und=%b st=%b rptr=%b want 1 1 00010", bus.runderflow, bus.rundf_sticky, bus.rptr);
    end
    cycle(0, m_wr, 2, 0);
    cycle(1, m_wr, 2, 1);
    checks++;
    if (bus.rundf_sticky !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins: got %b want 1", bus.rundf_sticky);
    end
    cycle(0, m_wr, 2, 1);
    checks++;
    if (bus.rundf_sticky !== 1'b0 || bus.runderflow !== 1'b0) begin
      errors++; $display("FAIL sticky_clear: got st=%b und=%b want 0 0", bus.rundf_sticky, bus.runderflow);
    end
  endtask

  // Reset asserted mid-cycle must clear the outputs before any clock edge.
  task automatic test_async_reset();
    cycle(0, (m_wr + 5) % MOD, 2, 0);
    @(negedge rclk);
    #2 rrst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge rclk);
    bus.rq2_wptr = '0;
    rrst_n = 1'b1;
    model_reset();
  endtask

  // Full depth twice: the second pass crosses the pointer wrap.
  task automatic test_wrap();
    cycle(0, 16, 2, 0);
    checks++;
    if (bus.rlevel !== 5'd16) begin
      errors++; $display("FAIL full_level: got %0d want 16", bus.rlevel);
    end
    for (int k = 0; k < 16; k++) cycle(1, 16, 2, 0);
    checks++;
    if (bus.rempty !== 1'b1 || bus.rptr !== 5'b11000) begin
      errors++; $display("FAIL first_pass: got e=%b rptr=%b want 1 11000", bus.rempty, bus.rptr);
    end
    cycle(0, 32, 2, 0);
    checks++;
    if (bus.rlevel !== 5'd16) begin
      errors++; $display("FAIL wrap_level: got %0d want 16", bus.rlevel);
    end
    for (int k = 0; k < 16; k++) cycle(1, 32, 2, 0);
    checks++;
    if (bus.rempty !== 1'b1 || bus.rptr !== '0 || bus.raddr !== '0) begin
      errors++; $display("FAIL wrap_end: got e=%b rptr=%b raddr=%0d want 1 0 0", bus.rempty, bus.rptr, bus.raddr);
    end
  endtask

  // A read and a write-pointer advance land in the same evaluation.
  task automatic test_simultaneous();
    cycle(0, m_wr + 4, 2, 0);
    cycle(1, m_wr + 2, 2, 0);
    checks++;
    if (bus.rlevel !== 5'd5 || bus.rempty !== 1'b0) begin
      errors++; $display("FAIL simultaneous: got level=%0d e=%b want 5 0", bus.rlevel, bus.rempty);
    end
  endtask

  // Random reads, legal write advances, threshold changes and error clears.
  task automatic test_random();
    int wr, room, th;
    for (int k = 0; k < 400; k++) begin
      room = 16 - m_level;
      wr = m_wr;
      if ($urandom_range(0, 2) == 0) wr = m_wr + $urandom_range(0, room);
      th = $urandom_range(0, 16);
      cycle(bit'($urandom_range(0, 1)), wr % MOD, th, ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_async_reset();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
